// File: rtl/adressed_fifo_bank.sv
// adressed_fifo_bank: bank of independent FIFO channels behind one shared address/data bus.
// read_enable pushes data_in into the selected channel, write_enable pops onto data_out.
module adressed_fifo_bank #(
    parameter int channel_count = 4,
    parameter int base_adress = 0,
    parameter int adress_width = 4,
    parameter int data_width = 8,
    parameter int length_as_power_of_2 = 4,
    parameter logic [channel_count-1:0] accept_mask = '1,
    parameter logic [channel_count-1:0] emit_mask = '1,
    parameter int almost_full_level = 2**length_as_power_of_2 - 1
) (
    input  logic clock,
    input  logic resetn,
    input  logic [adress_width-1:0] active_adress,
    input  logic [data_width-1:0] data_in,
    input  logic read_enable,
    input  logic write_enable,
    input  logic error_clear,
    output logic [data_width-1:0] data_out,
    output logic [length_as_power_of_2:0] selected_count,
    output logic [channel_count-1:0] full,
    output logic [channel_count-1:0] empty,
    output logic [channel_count-1:0] almost_full,
    output logic [channel_count-1:0] overflow,
    output logic [channel_count-1:0] underflow
);
    localparam int pw = length_as_power_of_2;
    localparam int depth = 2**pw;
    logic [data_width-1:0] pop_word [channel_count];
    logic [pw:0] sel_count [channel_count];
    logic [data_width-1:0] emit_word;
    for (genvar k = 0; k < channel_count; k++) begin : g_ch
        logic [data_width-1:0] mem [depth];
        logic [pw-1:0] wr_ptr, rd_ptr;
        logic [pw:0] count;
        logic hit, acc, em, push, pop, ovf_q, unf_q;
        assign hit = 32'(active_adress) == 32'(base_adress + k);
        assign acc = hit && read_enable && accept_mask[k];
        assign em = hit && write_enable && emit_mask[k];
        assign pop = em && !empty[k];
        // a full channel may still accept when the same edge frees a slot
        assign push = acc && (!full[k] || pop);
        assign full[k] = count[pw];
        assign empty[k] = count == '0;
        assign almost_full[k] = 32'(count) >= 32'(almost_full_level);
        assign overflow[k] = ovf_q;
        assign underflow[k] = unf_q;
        assign pop_word[k] = pop ? mem[rd_ptr] : '0;
        assign sel_count[k] = hit ? count : '0;
        always_ff @(posedge clock)
            if (push) mem[wr_ptr] <= data_in;
        always_ff @(posedge clock or negedge resetn)
            if (!resetn) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count <= '0;
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
            end else begin
                wr_ptr <= wr_ptr + pw'(push);
                rd_ptr <= rd_ptr + pw'(pop);
                count <= count + (pw+1)'(push) - (pw+1)'(pop);
                ovf_q <= !error_clear && (ovf_q || (acc && !push));
                unf_q <= !error_clear && (unf_q || (em && !pop));
            end
    end
    // at most one channel is selected, so OR-reducing picks its contribution
    always_comb begin
        emit_word = '0;
        selected_count = '0;
        for (int i = 0; i < channel_count; i++) begin
            emit_word = emit_word | pop_word[i];
            selected_count = selected_count | sel_count[i];
        end
    end
    always_ff @(posedge clock or negedge resetn)
        if (!resetn) data_out <= '0;
        else data_out <= emit_word;
endmodule

// File: doc/adressed_fifo_bank.md
# adressed_fifo_bank

Bank of `channel_count` independent FIFOs behind one shared address/data bus. Each channel answers at its own address in a contiguous window starting at `base_adress`, and each channel has its own access mode (accept-only, emit-only or both). Each channel reports full, empty and almost-full status and records sticky overflow/underflow errors. The occupancy of the currently addressed channel is also reported. The bank is the buffering stage between the bus decoder and the UART TX/RX channels.

## Interface
- `channel_count`, 4: number of FIFO channels; legal range 1..2**`adress_width`.
- `base_adress`, 0: address of channel 0; channel k answers at `base_adress`+k.
- `adress_width`, 4: width of `active_adress`.
- `data_width`, 8: word width.
- `length_as_power_of_2`, 4: each channel holds 2**`length_as_power_of_2` words.
- `accept_mask`, all ones (`channel_count` bits): bit k set means channel k may accept words from `data_in`.
- `emit_mask`, all ones (`channel_count` bits): bit k set means channel k may emit words to `data_out`.
- `almost_full_level`, 2**`length_as_power_of_2`-1: occupancy at or above which `almost_full[k]` is set.

Ports:
- `clock`  in  1: the only clock; all state updates on the rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `active_adress`  in  `adress_width`: selects the channel; addresses outside the window select nothing.
- `data_in`  in  `data_width`: word to accept.
- `read_enable`  in  1: bus-to-FIFO transfer; the selected channel captures `data_in`.
- `write_enable`  in  1: FIFO-to-bus transfer; the selected channel emits its oldest word.
- `error_clear`  in  1: clears all sticky error flags.
- `data_out`  out  `data_width`: emitted word, registered.
- `selected_count`  out  `length_as_power_of_2`+1: occupancy of the selected channel; 0 when no channel is selected.
- `full`, `empty`, `almost_full`  out  `channel_count`: per-channel status bits.
- `overflow`, `underflow`  out  `channel_count`: per-channel sticky error bits.

## Operation
- Select: channel k is selected when `active_adress` equals `base_adress`+k, compared at full width with no wrap. At most one channel is selected at a time.
- Accept: the selected channel captures `data_in` when `read_enable`=1, `accept_mask[k]`=1 and the channel is not full.
  - Accept into a full channel without a simultaneous emit: the word is dropped and `overflow[k]` is set.
- Emit: the selected channel pops its oldest word when `write_enable`=1 and `emit_mask[k]`=1.
  - Non-empty channel: the popped word is loaded into `data_out`.
  - Empty channel: `data_out` is loaded with 0 and `underflow[k]` is set.
- When no emit takes place in a cycle, `data_out` is loaded with 0.
- A masked-off direction is a silent no-op: no state change, no error flag.
- Accept and emit in the same cycle on the same channel:
  - Not empty and not full: both take effect and the count is unchanged.
  - Full: both take effect; no overflow.
  - Empty: only the accept takes effect. There is no bypass, `data_out` is 0 and `underflow` is set.
- Non-selected channels hold all state.
- Pointers are `length_as_power_of_2` bits and wrap naturally. Count ranges 0..2**`length_as_power_of_2`.
- Status flags: `full[k]` = (count == depth), `empty[k]` = (count == 0), `almost_full[k]` = (count ≥ `almost_full_level`).
- `error_clear` takes priority over a same-cycle set: all flags read 0 after that edge.
- Reset:
  - All pointers and counts are 0, `data_out` = 0, `full` = 0, `empty` = all ones.
  - `almost_full` = 0, unless `almost_full_level` is 0, in which case it is all ones.
  - `overflow` = `underflow` = 0.
  - An asynchronous reset in the middle of a transfer discards all stored data immediately.

## Timing
- Accept latency: a word captured at edge N can be emitted at edge N+1 and is visible on `data_out` after edge N+1.
- Emit latency: `data_out` is valid after the emitting edge and stays valid for exactly one cycle.
- Status (`full`, `empty`, `almost_full`, error flags) changes only on rising edges and reflects the post-edge count.
- `selected_count` is combinational from `active_adress` and the registered counts.
- Handshake: none. The bus master must check `full`/`empty` itself. Dropped words are reported only through the error flags.
- Throughput: one accept and one emit per cycle, with the same channel allowed for both.

## Test plan
- Reset, then 6 accepts of values 1..6 to channel 2 (depth 4, `base_adress`=4, address 6) -> `full[2]`=1 after the 4th accept; `overflow[2]`=1 after the 5th; `selected_count`=4.
- Emit 5 times from channel 2 -> `data_out` = 1,2,3,4,0 on successive cycles; `empty[2]`=1 after the 4th emit; `underflow[2]`=1 after the 5th; assert `error_clear` -> both error flags are 0.
- Interleaved traffic: accept 0xA1 to channel 0 and 0xB1 to channel 1, then emit from channel 1 -> `data_out`=0xB1; `selected_count` of channel 0 stays 1.
- Channel 1 full, simultaneous accept 9 and emit -> oldest word emitted, 9 stored, `full[1]` stays 1, no overflow; then 8 accept/emit pairs -> FIFO order preserved across pointer wrap.
- `accept_mask`=4'b0111, accept to channel 3; address 3 (outside the window) with both enables -> no state change anywhere, `selected_count`=0, `data_out`=0.
- Fill channel 0 to 3 words with `almost_full_level`=3 -> `almost_full[0]`=1; pulse `resetn` low in mid-cycle -> all outputs immediately return to their reset values.
